bcd_mod_counter: RTL and testbench
==================================

// Module: bcd_mod_counter
// PURPOSE
//  Parametrised two-digit BCD modulo counter; the generic successor of the fixed hours counter.
//  One instance per time field (hours mod 24, minutes/seconds mod 60).
//  Adds: any modulus 2..99, decrement editing, direct BCD load with range check, and a registered carry.
//  Instances chain CarryOut -> InTick of the next field.
// PARAMETERS
//  MODULUS         24   count range 0..MODULUS-1; legal 2..99
//  RESET_VALUE     0    binary value loaded on reset; must be < MODULUS
//  FREEZE_ON_EDIT  1    1: InTick ignored while EditEnable=1; 0: InTick still counts
//  EDIT_CARRY      0    1: edit-driven wraps also pulse CarryOut/BorrowOut; 0: only InTick wraps carry
// PORTS
//  CLK         in   1  system clock, all state on rising edge
//  RST_N       in   1  asynchronous active-low reset
//  InTick      in   1  one-cycle advance pulse (e.g. CarryOut of lower field)
//  EditEnable  in   1  edit mode; qualifies Increment/Decrement
//  Increment   in   1  one-cycle pulse: +1 with wrap (only when EditEnable=1)
//  Decrement   in   1  one-cycle pulse: -1 with wrap (only when EditEnable=1)
//  Load        in   1  one-cycle pulse: load LoadMSD/LoadLSD
//  LoadMSD     in   4  BCD tens digit to load
//  LoadLSD     in   4  BCD units digit to load
//  MSD         out  4  BCD tens digit of count
//  LSD         out  4  BCD units digit of count
//  CarryOut    out  1  registered one-cycle pulse on wrap MODULUS-1 -> 0
//  BorrowOut   out  1  registered one-cycle pulse on wrap 0 -> MODULUS-1
//  LoadErr     out  1  sticky; set on rejected load, cleared by next accepted load or reset
// BEHAVIOUR
//  Reset (RST_N=0, async): MSD/LSD = BCD(RESET_VALUE); CarryOut=BorrowOut=LoadErr=0.
//  All updates take effect on the rising CLK edge that samples the request; zero added latency.
//  CarryOut/BorrowOut go high on that same edge and low on the next, unless a further wrap occurs.
//  Per-edge priority, one action per cycle:
//   1 Load=1: accept iff LoadMSD<=9, LoadLSD<=9 and 10*MSD+LSD < MODULUS.
//     Accept: count <= loaded value, LoadErr <= 0. Reject: count held, LoadErr <= 1.
//     Load never pulses Carry/Borrow. Coincident InTick/edit requests are dropped.
//   2 EditEnable=1 and Increment xor Decrement: step +1 or -1 with modulo wrap.
//     Increment and Decrement both high: no change.
//     With FREEZE_ON_EDIT=0 and coincident InTick, an edit +1 and the tick combine:
//     net +2 for Increment, net 0 for Decrement; at most one carry pulse.
//   3 InTick=1 (not frozen): +1 with modulo wrap; CarryOut pulses on wrap.
//  Increment/Decrement while EditEnable=0 are ignored.
//  Arithmetic stays in BCD digits:
//   +1: LSD=9 -> LSD=0, MSD+1; count=MODULUS-1 -> 00.
//   -1: LSD=0 -> LSD=9, MSD-1; count=00 -> BCD(MODULUS-1).
//  Modulo check compares the full two-digit value, so 23->00 for 24 and 59->00 for 60.
//  Outputs never leave 0..MODULUS-1 and never show a non-BCD digit.
//  Edit-driven wrap pulses Carry/Borrow only when EDIT_CARRY=1.
//  Reset asserted mid-pulse clears all outputs immediately.
//  First edge after RST_N release behaves normally; no dead cycle.
//  Internal: BCD digit registers plus next-value logic; no binary-to-BCD divider.
// TESTING
//  MODULUS=24: reset, 24 InTick pulses -> 01..23 then 00; CarryOut exactly on the 24th edge only.
//  MODULUS=60: count from 59, InTick -> 00, CarryOut=1 one cycle; EditEnable=1, Decrement at 00 -> 59, BorrowOut=0 (EDIT_CARRY=0).
//  MODULUS=24: Load 2/4 -> count held, LoadErr=1; Load 1/A -> rejected; Load 1/9 -> 19, LoadErr=0.
//  FREEZE_ON_EDIT=1: EditEnable=1, InTick every cycle, no Increment -> count constant; Increment+Decrement together -> constant.
//  FREEZE_ON_EDIT=0: count 22, InTick+Increment same edge -> 00, single CarryOut pulse.
//  RST_N low between edges while count=17 and CarryOut high -> 00/0 immediately, without waiting for CLK; RESET_VALUE=12 variant -> 12.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD modulo counter with edit, load and registered carry/borrow
module bcd_mod_counter #(
  parameter int MODULUS        = 24,
  parameter int RESET_VALUE    = 0,
  parameter int FREEZE_ON_EDIT = 1,
  parameter int EDIT_CARRY     = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       InTick,
  input  logic       EditEnable,
  input  logic       Increment,
  input  logic       Decrement,
  input  logic       Load,
  input  logic [3:0] LoadMSD,
  input  logic [3:0] LoadLSD,
  output logic [3:0] MSD,
  output logic [3:0] LSD,
  output logic       CarryOut,
  output logic       BorrowOut,
  output logic       LoadErr
);

  localparam logic [3:0] MAX_MSD = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] MAX_LSD = 4'((MODULUS - 1) % 10);
  localparam logic [3:0] RST_MSD = 4'(RESET_VALUE / 10);
  localparam logic [3:0] RST_LSD = 4'(RESET_VALUE % 10);
  localparam logic [7:0] MOD8    = 8'(MODULUS);
  localparam logic       FREEZE  = (FREEZE_ON_EDIT != 0);
  localparam logic       ECARRY  = (EDIT_CARRY != 0);

  logic [3:0] msd_q, msd_d, lsd_q, lsd_d;
  logic       carry_q, carry_d, borrow_q, borrow_d, err_q, err_d;
  logic       edit_inc, edit_dec, tick_en, ld_ok;
  logic [7:0] ld_val;
  logic [8:0] step1, step2;

  // Result packing: {wrapped, msd, lsd}
  function automatic logic [8:0] bcd_inc(input logic [3:0] m, input logic [3:0] l);
    if (m == MAX_MSD && l == MAX_LSD) return {1'b1, 8'h00};
    else if (l == 4'd9)               return {1'b0, m + 4'd1, 4'd0};
    else                              return {1'b0, m, l + 4'd1};
  endfunction

  function automatic logic [8:0] bcd_dec(input logic [3:0] m, input logic [3:0] l);
    if (m == 4'd0 && l == 4'd0) return {1'b1, MAX_MSD, MAX_LSD};
    else if (l == 4'd0)         return {1'b0, m - 4'd1, 4'd9};
    else                        return {1'b0, m, l - 4'd1};
  endfunction

  always_comb begin
    msd_d    = msd_q;
    lsd_d    = lsd_q;
    err_d    = err_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    step1    = 9'd0;
    step2    = 9'd0;
    edit_inc = EditEnable & Increment & ~Decrement;
    edit_dec = EditEnable & Decrement & ~Increment;
    tick_en  = InTick & ~(FREEZE & EditEnable);
    ld_val   = {4'd0, LoadMSD} * 8'd10 + {4'd0, LoadLSD};
    ld_ok    = (LoadMSD <= 4'd9) && (LoadLSD <= 4'd9) && (ld_val < MOD8);

    if (Load) begin
      if (ld_ok) begin
        msd_d = LoadMSD;
        lsd_d = LoadLSD;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (edit_inc) begin
      step1 = bcd_inc(msd_q, lsd_q);
      if (tick_en) begin
        // Edit step applied first, then the tick; only one carry pulse can result
        step2   = bcd_inc(step1[7:4], step1[3:0]);
        {msd_d, lsd_d} = step2[7:0];
        carry_d = step2[8] | (ECARRY & step1[8]);
      end else begin
        {msd_d, lsd_d} = step1[7:0];
        carry_d = ECARRY & step1[8];
      end
    end else if (edit_dec) begin
      // A coincident unfrozen tick cancels the decrement exactly
      if (!tick_en) begin
        step1    = bcd_dec(msd_q, lsd_q);
        {msd_d, lsd_d} = step1[7:0];
        borrow_d = ECARRY & step1[8];
      end
    end else if (tick_en) begin
      step1   = bcd_inc(msd_q, lsd_q);
      {msd_d, lsd_d} = step1[7:0];
      carry_d = step1[8];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      msd_q    <= RST_MSD;
      lsd_q    <= RST_LSD;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      msd_q    <= msd_d;
      lsd_q    <= lsd_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign MSD       = msd_q;
  assign LSD       = lsd_q;
  assign CarryOut  = carry_q;
  assign BorrowOut = borrow_q;
  assign LoadErr   = err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb/tb_bcd_mod_counter.sv - directed self-checking bench for bcd_mod_counter
module tb_bcd_mod_counter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       InTick, EditEnable, Increment, Decrement;
  logic [3:0] ld_sel;
  logic [3:0] LoadMSD, LoadLSD;
  logic [3:0] msd_o [4];
  logic [3:0] lsd_o [4];
  logic       carry_o [4];
  logic       borrow_o [4];
  logic       err_o [4];
  int         passed = 0;
  int         total  = 0;

  always #5 CLK = ~CLK;

  // 0: mod 24, 1: mod 60, 2: mod 24 unfrozen, 3: mod 24 reset to 12
  bcd_mod_counter #(.MODULUS(24), .RESET_VALUE(0), .FREEZE_ON_EDIT(1), .EDIT_CARRY(0)) u24 (
    .CLK(CLK), .RST_N(RST_N), .InTick(InTick), .EditEnable(EditEnable), .Increment(Increment),
    .Decrement(Decrement), .Load(ld_sel[0]), .LoadMSD(LoadMSD), .LoadLSD(LoadLSD),
    .MSD(msd_o[0]), .LSD(lsd_o[0]), .CarryOut(carry_o[0]), .BorrowOut(borrow_o[0]), .LoadErr(err_o[0]));
  bcd_mod_counter #(.MODULUS(60), .RESET_VALUE(0), .FREEZE_ON_EDIT(1), .EDIT_CARRY(0)) u60 (
    .CLK(CLK), .RST_N(RST_N), .InTick(InTick), .EditEnable(EditEnable), .Increment(Increment),
    .Decrement(Decrement), .Load(ld_sel[1]), .LoadMSD(LoadMSD), .LoadLSD(LoadLSD),
    .MSD(msd_o[1]), .LSD(lsd_o[1]), .CarryOut(carry_o[1]), .BorrowOut(borrow_o[1]), .LoadErr(err_o[1]));
  bcd_mod_counter #(.MODULUS(24), .RESET_VALUE(0), .FREEZE_ON_EDIT(0), .EDIT_CARRY(0)) u24f (
    .CLK(CLK), .RST_N(RST_N), .InTick(InTick), .EditEnable(EditEnable), .Increment(Increment),
    .Decrement(Decrement), .Load(ld_sel[2]), .LoadMSD(LoadMSD), .LoadLSD(LoadLSD),
    .MSD(msd_o[2]), .LSD(lsd_o[2]), .CarryOut(carry_o[2]), .BorrowOut(borrow_o[2]), .LoadErr(err_o[2]));
  bcd_mod_counter #(.MODULUS(24), .RESET_VALUE(12), .FREEZE_ON_EDIT(1), .EDIT_CARRY(0)) u24r (
    .CLK(CLK), .RST_N(RST_N), .InTick(InTick), .EditEnable(EditEnable), .Increment(Increment),
    .Decrement(Decrement), .Load(ld_sel[3]), .LoadMSD(LoadMSD), .LoadLSD(LoadLSD),
    .MSD(msd_o[3]), .LSD(lsd_o[3]), .CarryOut(carry_o[3]), .BorrowOut(borrow_o[3]), .LoadErr(err_o[3]));

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    InTick = 0; EditEnable = 0; Increment = 0; Decrement = 0;
    ld_sel = 4'b0; LoadMSD = 4'd0; LoadLSD = 4'd0;
  endtask

  task automatic do_load(input logic [3:0] sel, input logic [3:0] m, input logic [3:0] l);
    ld_sel = sel; LoadMSD = m; LoadLSD = l;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    RST_N = 1'b0;
    step(); step();
    total++;
    if ({msd_o[0], lsd_o[0], carry_o[0], borrow_o[0], err_o[0]} !== {4'd0, 4'd0, 3'b000})
      $display("FAIL reset_u24: got %h%h c%b b%b e%b want 00 c0 b0 e0",
               msd_o[0], lsd_o[0], carry_o[0], borrow_o[0], err_o[0]);
    else passed++;
    total++;
    if ({msd_o[3], lsd_o[3]} !== {4'd1, 4'd2})
      $display("FAIL reset_value12: got %h%h want 12", msd_o[3], lsd_o[3]);
    else passed++;
    RST_N = 1'b1;
  endtask

  task automatic test_count24();
    logic [3:0] em, el;
    InTick = 1;
    for (int i = 1; i <= 24; i++) begin
      step();
      em = 4'((i % 24) / 10);
      el = 4'((i % 24) % 10);
      total++;
      if ({msd_o[0], lsd_o[0], carry_o[0]} !== {em, el, (i == 24)})
        $display("FAIL count24_tick%0d: got %h%h c%b want %h%h c%b",
                 i, msd_o[0], lsd_o[0], carry_o[0], em, el, (i == 24));
      else passed++;
    end
    idle();
    step();
    total++;
    if ({msd_o[0], lsd_o[0], carry_o[0]} !== {8'h00, 1'b0})
      $display("FAIL count24_carry_drop: got %h%h c%b want 00 c0", msd_o[0], lsd_o[0], carry_o[0]);
    else passed++;
  endtask

  task automatic test_wrap60();
    do_load(4'b0010, 4'd5, 4'd9);
    total++;
    if ({msd_o[1], lsd_o[1]} !== 8'h59) $display("FAIL wrap60_load: got %h%h want 59", msd_o[1], lsd_o[1]);
    else passed++;
    InTick = 1;
    step();
    idle();
    total++;
    if ({msd_o[1], lsd_o[1], carry_o[1]} !== {8'h00, 1'b1})
      $display("FAIL wrap60_tick: got %h%h c%b want 00 c1", msd_o[1], lsd_o[1], carry_o[1]);
    else passed++;
    EditEnable = 1; Decrement = 1;
    step();
    idle();
    total++;
    if ({msd_o[1], lsd_o[1], carry_o[1], borrow_o[1]} !== {8'h59, 2'b00})
      $display("FAIL wrap60_dec: got %h%h c%b b%b want 59 c0 b0", msd_o[1], lsd_o[1], carry_o[1], borrow_o[1]);
    else passed++;
    Decrement = 1;
    step();
    idle();
    total++;
    if ({msd_o[1], lsd_o[1]} !== 8'h59)
      $display("FAIL wrap60_dec_no_edit: got %h%h want 59", msd_o[1], lsd_o[1]);
    else passed++;
  endtask

  task automatic test_load();
    do_load(4'b0001, 4'd1, 4'd5);
    do_load(4'b0001, 4'd2, 4'd4);
    total++;
    if ({msd_o[0], lsd_o[0], err_o[0]} !== {8'h15, 1'b1})
      $display("FAIL load_24: got %h%h e%b want 15 e1", msd_o[0], lsd_o[0], err_o[0]);
    else passed++;
    do_load(4'b0001, 4'd1, 4'hA);
    total++;
    if ({msd_o[0], lsd_o[0], err_o[0]} !== {8'h15, 1'b1})
      $display("FAIL load_1A: got %h%h e%b want 15 e1", msd_o[0], lsd_o[0], err_o[0]);
    else passed++;
    do_load(4'b0001, 4'd1, 4'd9);
    total++;
    if ({msd_o[0], lsd_o[0], err_o[0]} !== {8'h19, 1'b0})
      $display("FAIL load_19: got %h%h e%b want 19 e0", msd_o[0], lsd_o[0], err_o[0]);
    else passed++;
    do_load(4'b0001, 4'd2, 4'd3);
    InTick = 1; ld_sel = 4'b0001; LoadMSD = 4'd0; LoadLSD = 4'd3;
    step();
    idle();
    total++;
    if ({msd_o[0], lsd_o[0], carry_o[0]} !== {8'h03, 1'b0})
      $display("FAIL load_over_tick: got %h%h c%b want 03 c0", msd_o[0], lsd_o[0], carry_o[0]);
    else passed++;
  endtask

  task automatic test_freeze();
    do_load(4'b0001, 4'd1, 4'd0);
    EditEnable = 1; InTick = 1;
    step(); step(); step();
    total++;
    if ({msd_o[0], lsd_o[0]} !== 8'h10) $display("FAIL freeze_tick: got %h%h want 10", msd_o[0], lsd_o[0]);
    else passed++;
    Increment = 1; Decrement = 1;
    step();
    idle();
    total++;
    if ({msd_o[0], lsd_o[0]} !== 8'h10) $display("FAIL freeze_incdec: got %h%h want 10", msd_o[0], lsd_o[0]);
    else passed++;
    do_load(4'b0001, 4'd2, 4'd3);
    EditEnable = 1; Increment = 1;
    step();
    idle();
    total++;
    if ({msd_o[0], lsd_o[0], carry_o[0]} !== {8'h00, 1'b0})
      $display("FAIL edit_wrap_nocarry: got %h%h c%b want 00 c0", msd_o[0], lsd_o[0], carry_o[0]);
    else passed++;
    do_load(4'b0001, 4'd1, 4'd0);
    EditEnable = 1; Decrement = 1;
    step();
    idle();
    total++;
    if ({msd_o[0], lsd_o[0]} !== 8'h09) $display("FAIL edit_dec_digit: got %h%h want 09", msd_o[0], lsd_o[0]);
    else passed++;
  endtask

  task automatic test_nofreeze();
    do_load(4'b0100, 4'd2, 4'd2);
    EditEnable = 1; Increment = 1; InTick = 1;
    step();
    idle();
    total++;
    if ({msd_o[2], lsd_o[2], carry_o[2]} !== {8'h00, 1'b1})
      $display("FAIL nofreeze_plus2: got %h%h c%b want 00 c1", msd_o[2], lsd_o[2], carry_o[2]);
    else passed++;
    EditEnable = 1; Decrement = 1; InTick = 1;
    step();
    idle();
    total++;
    if ({msd_o[2], lsd_o[2], carry_o[2]} !== {8'h00, 1'b0})
      $display("FAIL nofreeze_dec_tick: got %h%h c%b want 00 c0", msd_o[2], lsd_o[2], carry_o[2]);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_load(4'b0010, 4'd5, 4'd9);
    do_load(4'b1001, 4'd1, 4'd6);
    InTick = 1;
    step();
    idle();
    total++;
    if ({msd_o[0], lsd_o[0], carry_o[1]} !== {8'h17, 1'b1})
      $display("FAIL async_pre: got %h%h c%b want 17 c1", msd_o[0], lsd_o[0], carry_o[1]);
    else passed++;
    #2 RST_N = 1'b0;
    #1;
    total++;
    if ({msd_o[0], lsd_o[0], carry_o[1], msd_o[3], lsd_o[3]} !== {8'h00, 1'b0, 8'h12})
      $display("FAIL async_reset: got %h%h c%b r%h%h want 00 c0 r12",
               msd_o[0], lsd_o[0], carry_o[1], msd_o[3], lsd_o[3]);
    else passed++;
    #1 RST_N = 1'b1;
    InTick = 1;
    step();
    idle();
    total++;
    if ({msd_o[0], lsd_o[0], msd_o[3], lsd_o[3]} !== 16'h0113)
      $display("FAIL first_edge: got %h%h r%h%h want 01 r13", msd_o[0], lsd_o[0], msd_o[3], lsd_o[3]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_count24();
    test_wrap60();
    test_load();
    test_freeze();
    test_nofreeze();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
